clken_gen_multi: RTL and testbench
==================================

// Module: clken_gen_multi
// PURPOSE
//   Multi-channel, runtime-programmable clock-enable generator; successor to the fixed single divider.
//   Each channel emits a one-cycle enable pulse every D clk cycles.
//   D is reprogrammable at run time and switches glitch-free, on a period boundary only.
//   Drives CPU fast/slow speed (CSH/CSL), timer prescaler and PSG sample strobes from one master clk.
// PARAMETERS
//   NCH      2    number of independent enable channels (>=1)
//   CW       8    divisor width per channel; D range 1..2**CW-1
//   DEF_DIV  4    divisor loaded into every channel at reset (1..2**CW-1)
// PORTS
//   clk        in   1        master clock, all logic on posedge
//   reset_n    in   1        synchronous active-low reset
//   div_i      in   NCH*CW   new divisor, channel k at [k*CW +: CW]
//   div_wr_i   in   NCH      per-channel write strobe for div_i slice
//   sync_i     in   1        restart all channels' phase together
//   en_o       out  NCH      registered enable pulses
//   pend_o     out  NCH      divisor write accepted, not yet applied
//   halt_i     in   1        (CLKEN_HALT_EN only) freeze all channels
// BEHAVIOUR
//   Reset:
//   - reset_n low at a posedge: count=0, div_cur=DEF_DIV, div_pend=DEF_DIV.
//   - Also clears en_o=0 and pend_o=0; all channels identical.
//   Period:
//   - First en_o pulse is in the cycle after the first posedge sampling reset_n high.
//   - Then exactly one pulse per D cycles (D = div_cur); en_o is a pure function of the count register.
//   - D=1: en_o held high continuously. Written D=0 is stored as 1 (clamped on write).
//   Terminal cycle:
//   - The terminal cycle is the cycle whose posedge sets en_o high next.
//   - In it, count reloads to D-1.
//   - If pend is set, div_cur<=div_pend and pend clears; the new period starts from this pulse.
//   Write:
//   - div_wr_i[k] high: div_pend[k]<=div_i slice, pend_o[k]=1 next cycle.
//   - Write coinciding with terminal cycle: new value used for that same reload; pend_o stays 0.
//   - Multiple writes before terminal: last wins.
//   - Write of value equal to div_cur still sets pend (harmless).
//   sync_i:
//   - All channels treat this cycle as terminal: en_o all high next cycle, pending divisors applied.
//   - sync_i with div_wr_i same cycle: the written value is applied.
//   - Pulses already due next cycle are not duplicated.
//   Width/wrap:
//   - count is CW bits, decrements to 0, never wraps below 0.
//   - No arithmetic overflow possible since D<=2**CW-1.
//   Reset mid-period: aborts the period and discards pending writes; behaves exactly as power-up.
// CONFIGURATION
//   CLKEN_HALT_EN defined:
//   - halt_i port exists. While halt_i=1: counts frozen, en_o forced 0, pend applied only on resume.
//   - Writes still latch into div_pend; sync_i is ignored while halted.
//   - On halt_i falling, counting resumes from the frozen count; phase is preserved.
//   CLKEN_HALT_EN undefined: no halt_i port; behaves as halt_i tied 0.
// STRUCTURE
//   Package clocking_pkg: typedef div_t (logic [CW-1:0]); localparam DIV_MIN=1.
//   Package clocking_pkg also holds a clamp function for D=0 -> 1.
//   Sub-module clken_channel: one channel (count, div_cur, div_pend, pend, en); generate-looped NCH times.
//   Top-level holds only the per-channel div_i slicing and sync/halt fan-out.
// TESTING
//   Reset, NCH=2, DEF_DIV=4, no writes -> en_o[0] pulses at cycles 1,5,9,13 after release.
//   en_o[1] pulses identically to en_o[0].
//   Write D=2 to ch0 mid-period (count=2) -> pend_o[0]=1 until the next pulse.
//   Subsequent ch0 pulses are 2 apart; ch1 is unaffected.
//   Write D=7 exactly in the terminal cycle -> next interval is 7; pend_o never rises.
//   Write D=0 -> en_o constantly high after the next pulse.
//   sync_i pulse with ch0 D=3, ch1 D=5 out of phase -> both pulse the next cycle.
//   After sync: ch0 pulses every 3 and ch1 every 5 from there.
//   Reset asserted mid-period with pend set -> en_o=0, pend_o=0; DEF_DIV restored.
//   After mid-period reset: first pulse is in the cycle after release.
//   CLKEN_HALT_EN: halt 10 cycles at count=1 -> no pulses while halted.
//   After halt releases: pulse 2 cycles after release; period unchanged.

Source files
------------

// File: rtl/clocking_pkg.sv
// Shared clock-enable types, constants and the divisor clamp helper.
package clocking_pkg;

    localparam int unsigned DEF_CW  = 8;
    localparam int unsigned DIV_MIN = 1;

    typedef logic [DEF_CW-1:0] div_t;

    // A divisor of zero has no meaning; it is stored as the smallest legal period.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d == '0) ? 32'(DIV_MIN) : d;
    endfunction

endpackage

// File: rtl/clken_channel.sv
// One clock-enable channel: down-counter, active and pending divisor, registered pulse.
module clken_channel #(
    parameter int unsigned CW      = 8,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] div_i,
    input  logic          div_wr_i,
    input  logic          sync_i,
    input  logic          halt_i,
    output logic          en_o,
    output logic          pend_o
);
    import clocking_pkg::*;

    localparam logic [CW-1:0] DEF_D = CW'(DEF_DIV);

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] cur_q, cur_d;
    logic [CW-1:0] pval_q, pval_d;
    logic          pend_q, pend_d;
    logic          en_q, en_d;
    logic [CW-1:0] wr_val;
    logic [CW-1:0] next_div;
    logic          terminal;

    always_comb begin
        wr_val   = CW'(clamp_div(32'(div_i)));
        count_d  = count_q;
        cur_d    = cur_q;
        pval_d   = pval_q;
        pend_d   = pend_q;
        en_d     = 1'b0;
        terminal = 1'b0;
        // A write landing in the terminal cycle overrides whatever was pending.
        next_div = pend_q ? pval_q : cur_q;
        if (div_wr_i) begin
            next_div = wr_val;
        end
        if (halt_i) begin
            if (div_wr_i) begin
                pval_d = wr_val;
                pend_d = 1'b1;
            end
        end else begin
            terminal = sync_i || (count_q == '0);
            if (terminal) begin
                en_d    = 1'b1;
                cur_d   = next_div;
                pval_d  = next_div;
                pend_d  = 1'b0;
                count_d = next_div - 1'b1;
            end else begin
                count_d = count_q - 1'b1;
                if (div_wr_i) begin
                    pval_d = wr_val;
                    pend_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            cur_q   <= DEF_D;
            pval_q  <= DEF_D;
            pend_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            cur_q   <= cur_d;
            pval_q  <= pval_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
        end
    end

    assign en_o   = en_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clken_gen_multi.sv
// Multi-channel programmable clock-enable generator; optional halt_i under CLKEN_HALT_EN.
module clken_gen_multi #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned CW      = 8,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH*CW-1:0] div_i,
    input  logic [NCH-1:0]    div_wr_i,
    input  logic              sync_i,
`ifdef CLKEN_HALT_EN
    input  logic              halt_i,
`endif
    output logic [NCH-1:0]    en_o,
    output logic [NCH-1:0]    pend_o
);
    import clocking_pkg::*;

    logic halt;

`ifdef CLKEN_HALT_EN
    assign halt = halt_i;
`else
    assign halt = 1'b0;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        clken_channel #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .div_i    (div_i[k*CW +: CW]),
            .div_wr_i (div_wr_i[k]),
            .sync_i   (sync_i),
            .halt_i   (halt),
            .en_o     (en_o[k]),
            .pend_o   (pend_o[k])
        );
    end

endmodule

// File: tb/tb_clken_gen_multi.sv
// Bench for clken_gen_multi: directed scenarios plus random traffic against a pulse-schedule model.
module tb_clken_gen_multi;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int DEF = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH*CW-1:0] div;
    logic [NCH-1:0]    div_wr;
    logic              sync;
    logic              halt;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    pend;

    int errors = 0;
    int checks = 0;

    // Model: absolute edge index of each channel's next pulse, plus active/pending divisor.
    longint      n = 0;
    longint      nxt [NCH];
    int unsigned cur [NCH];
    int unsigned pv  [NCH];
    bit          pnd [NCH];
    bit          e_en [NCH];
    bit          e_pnd [NCH];

    clken_gen_multi #(
        .NCH     (NCH),
        .CW      (CW),
        .DEF_DIV (DEF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .div_i    (div),
        .div_wr_i (div_wr),
        .sync_i   (sync),
`ifdef CLKEN_HALT_EN
        .halt_i   (halt),
`endif
        .en_o     (en),
        .pend_o   (pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int unsigned clampv(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic tick();
        for (int k = 0; k < NCH; k++) begin
            int unsigned wv;
            wv = clampv(int'(div[k*CW +: CW]));
            if (!reset_n) begin
                nxt[k] = n + 1; cur[k] = DEF; pv[k] = DEF; pnd[k] = 0; e_en[k] = 0;
            end else if (halt) begin
                if (div_wr[k]) begin pv[k] = wv; pnd[k] = 1; end
                nxt[k] = nxt[k] + 1;
                e_en[k] = 0;
            end else if (sync || nxt[k] == n) begin
                if (div_wr[k]) cur[k] = wv;
                else if (pnd[k]) cur[k] = pv[k];
                pnd[k] = 0;
                nxt[k] = n + cur[k];
                e_en[k] = 1;
            end else begin
                if (div_wr[k]) begin pv[k] = wv; pnd[k] = 1; end
                e_en[k] = 0;
            end
            e_pnd[k] = pnd[k];
        end
        @(posedge clk);
        n++;
        #1;
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("en[%0d]", k), 32'(en[k]), 32'(e_en[k]));
            chk($sformatf("pend[%0d]", k), 32'(pend[k]), 32'(e_pnd[k]));
        end
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    task automatic wr_ch(input int k, input int unsigned v);
        div[k*CW +: CW] = CW'(v);
        div_wr[k] = 1'b1;
        tick();
        div_wr = '0;
    endtask

    initial begin
        reset_n = 1'b0; div = '0; div_wr = '0; sync = 1'b0; halt = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            nxt[k] = 0; cur[k] = DEF; pv[k] = DEF; pnd[k] = 0;
        end
        idle(3);
        reset_n = 1'b1;
        idle(14);

        // Mid-period write of D=2 to ch0 (count 2 is two edges after a pulse edge)
        while (nxt[0] != n + 2) tick();
        wr_ch(0, 2);
        idle(10);

        // D=7 written exactly in the terminal cycle
        while (nxt[0] != n) tick();
        wr_ch(0, 7);
        idle(16);

        // D=0 clamps to continuous enable
        wr_ch(0, 0);
        idle(12);

        // Out-of-phase ch0 D=3 / ch1 D=5, then a common sync
        wr_ch(0, 3);
        idle(2);
        wr_ch(1, 5);
        idle(7);
        sync = 1'b1; tick(); sync = 1'b0;
        idle(16);

        // sync together with a write
        div[CW +: CW] = CW'(6); div_wr[1] = 1'b1; sync = 1'b1;
        tick();
        div_wr = '0; sync = 1'b0;
        idle(14);

        // Reset mid-period with a pending write
        while (nxt[0] != n + 2) tick();
        wr_ch(0, 9);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        idle(14);

`ifdef CLKEN_HALT_EN
        // Halt for 10 cycles with count=1, write during halt
        while (nxt[0] != n + 1) tick();
        halt = 1'b1;
        idle(4);
        wr_ch(1, 3);
        idle(5);
        halt = 1'b0;
        idle(14);
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            div_wr = '0;
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 9) == 0) begin
                    div[k*CW +: CW] = ($urandom_range(0, 15) == 0) ? CW'($urandom) : CW'($urandom_range(0, 9));
                    div_wr[k] = 1'b1;
                end
            end
            sync    = ($urandom_range(0, 39) == 0);
            reset_n = ($urandom_range(0, 299) != 0);
`ifdef CLKEN_HALT_EN
            if ($urandom_range(0, 29) == 0) halt = ~halt;
`endif
            tick();
        end
        div_wr = '0; sync = 1'b0; reset_n = 1'b1; halt = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
